// File: rtl/tf_addr_gen.sv
// Twiddle-factor address generator: walks every NTT (CT) or INTT (GS) stage and issues
// one ROM address per butterfly unit per cycle, honouring a pipeline stall.
module tf_addr_gen #(
   parameter int unsigned LOGN      = 8,
   parameter int unsigned ADDRW     = 11,
   parameter int unsigned INTT_BASE = 1024
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             start,
   input  logic             op_in,
   input  logic             stall,
   output logic             busy,
   output logic             done,
   output logic             op,
   output logic             special_add,
   output logic [ADDRW-1:0] gamma1_add,
   output logic [ADDRW-1:0] gamma2_add,
   output logic             addr_valid,
   output logic [3:0]       stage_idx,
   output logic             last
);

   localparam int unsigned   CW     = (LOGN > 2) ? LOGN - 2 : 1;
   localparam int unsigned   CPS    = 32'd1 << (LOGN - 2);
   localparam logic [3:0]    S_LAST = 4'(LOGN - 1);
   localparam logic [CW-1:0] C_LAST = CW'(CPS - 1);

   if (LOGN < 2 || LOGN > 10 || ADDRW > 31 ||
       (INTT_BASE + (32'd1 << LOGN)) > (32'd1 << ADDRW)) begin : g_param_check
      $error("tf_addr_gen: illegal LOGN/ADDRW/INTT_BASE combination");
   end

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state_q, state_d;
   logic [3:0]       s_q, s_d;
   logic [CW-1:0]    c_q, c_d;
   logic             op_q, op_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             sp_q, sp_d;
   logic             valid_q, valid_d;
   logic             last_q, last_d;
   logic [ADDRW-1:0] g1_q, g1_d;
   logic [ADDRW-1:0] g2_q, g2_d;
   logic [3:0]       stg_q, stg_d;

   logic [3:0]       cur_s;
   logic [CW-1:0]    cur_c;
   logic             cur_op;
   logic [3:0]       sh_n;
   logic [ADDRW-1:0] k1, k2, a1, a2;
   logic             cur_sp, cur_fin;
   logic             issue;

   // Pair about to be issued: (0,0) with the incoming op on the start edge, else the live counters.
   always_comb begin
      cur_s  = (state_q == RUN) ? s_q  : 4'd0;
      cur_c  = (state_q == RUN) ? c_q  : '0;
      cur_op = (state_q == RUN) ? op_q : op_in;
      k1     = ADDRW'(cur_c) << 1;
      k2     = k1 | ADDRW'(1);
      sh_n   = S_LAST - cur_s;
      if (cur_op) begin
         a1     = ADDRW'(INTT_BASE) + (ADDRW'(1) << sh_n) + (k1 >> cur_s);
         a2     = ADDRW'(INTT_BASE) + (ADDRW'(1) << sh_n) + (k2 >> cur_s);
         cur_sp = (cur_s == 4'd0);
      end else begin
         a1     = (ADDRW'(1) << cur_s) + (k1 >> sh_n);
         a2     = (ADDRW'(1) << cur_s) + (k2 >> sh_n);
         cur_sp = (cur_s == S_LAST);
      end
      cur_fin = (cur_s == S_LAST) && (cur_c == C_LAST);
   end

   always_comb begin
      state_d = state_q;
      s_d     = s_q;
      c_d     = c_q;
      op_d    = op_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      g1_d    = g1_q;
      g2_d    = g2_q;
      sp_d    = sp_q;
      stg_d   = stg_q;
      valid_d = 1'b0;
      last_d  = 1'b0;
      issue   = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               state_d = RUN;
               op_d    = op_in;
               busy_d  = 1'b1;
               issue   = 1'b1;
            end
         end
         RUN:  issue = 1'b1;
         DONE: begin
            state_d = IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
         end
         default: state_d = IDLE;
      endcase
      // A stalled issue re-presents the same pair as invalid and leaves the counters put.
      if (issue) begin
         g1_d    = a1;
         g2_d    = a2;
         sp_d    = cur_sp;
         stg_d   = cur_s;
         valid_d = !stall;
         s_d     = cur_s;
         c_d     = cur_c;
         if (!stall) begin
            if (cur_fin) begin
               last_d  = 1'b1;
               state_d = DONE;
            end else if (cur_c == C_LAST) begin
               c_d = '0;
               s_d = cur_s + 4'd1;
            end else begin
               c_d = cur_c + CW'(1);
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         state_q <= IDLE;
         s_q     <= 4'd0;
         c_q     <= '0;
         op_q    <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         sp_q    <= 1'b0;
         valid_q <= 1'b0;
         last_q  <= 1'b0;
         g1_q    <= '0;
         g2_q    <= '0;
         stg_q   <= 4'd0;
      end else begin
         state_q <= state_d;
         s_q     <= s_d;
         c_q     <= c_d;
         op_q    <= op_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         sp_q    <= sp_d;
         valid_q <= valid_d;
         last_q  <= last_d;
         g1_q    <= g1_d;
         g2_q    <= g2_d;
         stg_q   <= stg_d;
      end
   end

   assign busy        = busy_q;
   assign done        = done_q;
   assign op          = op_q;
   assign special_add = sp_q;
   assign gamma1_add  = g1_q;
   assign gamma2_add  = g2_q;
   assign addr_valid  = valid_q;
   assign stage_idx   = stg_q;
   assign last        = last_q;

endmodule

// File: tb/tb_tf_addr_gen.sv
// Bench for tf_addr_gen: LOGN=3 and default LOGN=8 instances checked against an arithmetic model.
module tb_tf_addr_gen;

   localparam int unsigned AW = 11;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rstn;
   logic          start3, opi3, stall3, busy3, done3, op3, sp3, v3, last3;
   logic [AW-1:0] g13, g23;
   logic [3:0]    stg3;
   logic          start8, opi8, stall8, busy8, done8, op8, sp8, v8, last8;
   logic [AW-1:0] g18, g28;
   logic [3:0]    stg8;

   tf_addr_gen #(.LOGN(3), .ADDRW(AW), .INTT_BASE(1024)) dut3 (
      .clk(clk), .rstn(rstn), .start(start3), .op_in(opi3), .stall(stall3),
      .busy(busy3), .done(done3), .op(op3), .special_add(sp3),
      .gamma1_add(g13), .gamma2_add(g23), .addr_valid(v3), .stage_idx(stg3), .last(last3));

   tf_addr_gen dut8 (
      .clk(clk), .rstn(rstn), .start(start8), .op_in(opi8), .stall(stall8),
      .busy(busy8), .done(done8), .op(op8), .special_add(sp8),
      .gamma1_add(g18), .gamma2_add(g28), .addr_valid(v8), .stage_idx(stg8), .last(last8));

   typedef struct {
      int g1; int g2; bit sp; bit v; bit last; bit busy; bit done; bit op; int stg;
   } obs_t;
   typedef struct {
      int nv; int nd; int nb; int nl; int lastv; int lastc; int donec; int opbad;
   } st_t;

   obs_t tr[$];
   int   total = 0;
   int   bad   = 0;

   // Reference: stage s has half-group size h; unit k belongs to group k/h.
   function automatic void model(input int logn, input bit o, input int idx,
                                 output int e1, output int e2, output bit esp, output int est);
      int n, cps, s, c, half;
      n   = 1 << logn;
      cps = n / 4;
      s   = idx / cps;
      c   = idx % cps;
      if (!o) begin
         half = n >> (s + 1);
         e1   = (1 << s) + (2 * c) / half;
         e2   = (1 << s) + (2 * c + 1) / half;
      end else begin
         half = 1 << s;
         e1   = 1024 + (n / 2) / half + (2 * c) / half;
         e2   = 1024 + (n / 2) / half + (2 * c + 1) / half;
      end
      esp = (half == 1);
      est = s;
   endfunction

   function automatic bit stall_at(input int j, input int pct, input logic [63:0] mask);
      bit m;
      m = (j < 64) ? mask[j] : 1'b0;
      return m || (int'($urandom_range(99)) < pct);
   endfunction

   function automatic obs_t sample(input bit sel);
      obs_t r;
      if (sel) begin
         r.g1 = int'(g18); r.g2 = int'(g28); r.sp = sp8; r.v = v8; r.last = last8;
         r.busy = busy8; r.done = done8; r.op = op8; r.stg = int'(stg8);
      end else begin
         r.g1 = int'(g13); r.g2 = int'(g23); r.sp = sp3; r.v = v3; r.last = last3;
         r.busy = busy3; r.done = done3; r.op = op3; r.stg = int'(stg3);
      end
      return r;
   endfunction

   function automatic st_t summarize(input bit o);
      st_t t;
      t = '{default: 0};
      t.lastv = -1; t.lastc = -1; t.donec = -1;
      foreach (tr[i]) begin
         if (tr[i].last) begin
            t.nl++;
            t.lastc = i;
            t.lastv = tr[i].v ? t.nv : -2;
         end
         if (tr[i].v) t.nv++;
         if (tr[i].done) begin
            t.nd++;
            if (t.donec < 0) t.donec = i;
         end
         if (tr[i].busy) begin
            t.nb++;
            if (tr[i].op !== o) t.opbad++;
         end
      end
      return t;
   endfunction

   task automatic drive(input bit sel, input logic st, input logic o, input logic sl);
      if (sel) begin start8 = st; opi8 = o; stall8 = sl; end
      else     begin start3 = st; opi3 = o; stall3 = sl; end
   endtask

   // Launch one transform and record every cycle until done plus two idle cycles.
   task automatic run(input bit sel, input bit o, input int pct, input logic [63:0] mask,
                      input bit poke, output bit to);
      int after;
      bit seen;
      tr.delete();
      seen  = 1'b0;
      after = 0;
      @(negedge clk);
      drive(sel, 1'b1, o, stall_at(0, pct, mask));
      for (int j = 1; j <= 3000 && after < 3; j++) begin
         obs_t r;
         @(negedge clk);
         r = sample(sel);
         tr.push_back(r);
         if (r.done) seen = 1'b1;
         if (seen) begin
            after++;
            drive(sel, 1'b0, 1'b0, 1'b0);
         end else if (poke && r.busy && $urandom_range(2) == 0) begin
            drive(sel, 1'b1, ~o, stall_at(j, pct, mask));
         end else begin
            drive(sel, 1'b0, o, stall_at(j, pct, mask));
         end
      end
      drive(sel, 1'b0, 1'b0, 1'b0);
      to = (after < 3);
   endtask

   task automatic test_reset;
      rstn = 1'b0;
      drive(1'b0, 1'b0, 1'b0, 1'b0);
      drive(1'b1, 1'b0, 1'b0, 1'b0);
      repeat (3) @(posedge clk);
      @(negedge clk);
      total++;
      if ({busy3, done3, op3, sp3, v3, last3} !== 6'b0) begin
         bad++; $display("FAIL reset_ctl3: got %b expected 000000", {busy3, done3, op3, sp3, v3, last3});
      end
      total++;
      if ({g13, g23, stg3} !== 26'b0) begin
         bad++; $display("FAIL reset_addr3: got g1=%0d g2=%0d stg=%0d expected 0", g13, g23, stg3);
      end
      total++;
      if ({busy8, done8, op8, sp8, v8, last8, g18, g28, stg8} !== 32'b0) begin
         bad++; $display("FAIL reset_all8: got busy=%b done=%b g1=%0d expected 0", busy8, done8, g18);
      end
      rstn = 1'b1;
   endtask

   // Fixed LOGN=3 tables, no stall.
   task automatic test_fixed_tables(input bit o);
      int   t1[6], t2[6];
      bit   tsp[6];
      int   n;
      bit   to;
      st_t  st;
      if (!o) begin
         t1 = '{1, 1, 2, 3, 4, 6};          t2 = '{1, 1, 2, 3, 5, 7};
         tsp = '{0, 0, 0, 0, 1, 1};
      end else begin
         t1 = '{1028, 1030, 1026, 1027, 1025, 1025};
         t2 = '{1029, 1031, 1026, 1027, 1025, 1025};
         tsp = '{1, 1, 0, 0, 0, 0};
      end
      run(1'b0, o, 0, 64'b0, 1'b0, to);
      total++;
      if (to !== 1'b0) begin bad++; $display("FAIL table_timeout op=%0d: no done seen", o); end
      n = 0;
      foreach (tr[i]) if (tr[i].v) begin
         if (n < 6) begin
            total++;
            if (tr[i].g1 !== t1[n] || tr[i].g2 !== t2[n] || tr[i].sp !== tsp[n]) begin
               bad++;
               $display("FAIL table_pair op=%0d #%0d: got (%0d,%0d,%0d) expected (%0d,%0d,%0d)",
                        o, n, tr[i].g1, tr[i].g2, tr[i].sp, t1[n], t2[n], tsp[n]);
            end
         end
         n++;
      end
      st = summarize(o);
      total++;
      if (st.nv !== 6) begin bad++; $display("FAIL table_count op=%0d: got %0d expected 6", o, st.nv); end
      total++;
      if (st.nl !== 1 || st.lastv !== 5) begin
         bad++; $display("FAIL table_last op=%0d: got n=%0d at pair %0d expected 1 at pair 5", o, st.nl, st.lastv);
      end
      total++;
      if (st.nd !== 1 || st.donec !== st.lastc + 1) begin
         bad++; $display("FAIL table_done op=%0d: got n=%0d cyc=%0d expected 1 at cyc %0d", o, st.nd, st.donec, st.lastc + 1);
      end
      total++;
      if (st.nb !== 6) begin bad++; $display("FAIL table_busy op=%0d: got %0d cycles expected 6", o, st.nb); end
      total++;
      if (st.opbad !== 0) begin bad++; $display("FAIL table_op op=%0d: got %0d wrong cycles expected 0", o, st.opbad); end
   endtask

   task automatic test_stall_hold;
      bit  to;
      st_t st;
      int  idx, e1, e2, est;
      bit  esp;
      run(1'b0, 1'b0, 0, 64'b11100, 1'b0, to);
      total++;
      if (to !== 1'b0) begin bad++; $display("FAIL stall_timeout: no done seen"); end
      for (int i = 2; i <= 4; i++) begin
         total++;
         if (tr[i].v !== 1'b0 || tr[i].g1 !== 2 || tr[i].g2 !== 2) begin
            bad++; $display("FAIL stall_held cyc%0d: got v=%0d (%0d,%0d) expected v=0 (2,2)", i, tr[i].v, tr[i].g1, tr[i].g2);
         end
      end
      total++;
      if (tr[5].v !== 1'b1 || tr[5].g1 !== 2 || tr[5].g2 !== 2) begin
         bad++; $display("FAIL stall_release: got v=%0d (%0d,%0d) expected v=1 (2,2)", tr[5].v, tr[5].g1, tr[5].g2);
      end
      idx = 0;
      foreach (tr[i]) if (tr[i].v) begin
         model(3, 1'b0, idx, e1, e2, esp, est);
         total++;
         if (tr[i].g1 !== e1 || tr[i].g2 !== e2 || tr[i].sp !== esp || tr[i].stg !== est) begin
            bad++; $display("FAIL stall_seq #%0d: got (%0d,%0d,%0d) expected (%0d,%0d,%0d)", idx, tr[i].g1, tr[i].g2, tr[i].sp, e1, e2, esp);
         end
         idx++;
      end
      st = summarize(1'b0);
      total++;
      if (st.nv !== 6 || st.nd !== 1) begin
         bad++; $display("FAIL stall_count: got valid=%0d done=%0d expected 6/1", st.nv, st.nd);
      end
   endtask

   task automatic test_random_stall(input bit poke);
      bit  to, o;
      st_t st;
      int  idx, e1, e2, est;
      bit  esp;
      for (int it = 0; it < 6; it++) begin
         o = 1'($urandom_range(1));
         run(1'b0, o, 35, 64'($urandom_range(1)), poke, to);
         total++;
         if (to !== 1'b0) begin bad++; $display("FAIL rand_timeout poke=%0d it=%0d", poke, it); end
         idx = 0;
         foreach (tr[i]) if (tr[i].v) begin
            model(3, o, idx, e1, e2, esp, est);
            total++;
            if (tr[i].g1 !== e1 || tr[i].g2 !== e2 || tr[i].sp !== esp || tr[i].stg !== est) begin
               bad++; $display("FAIL rand_seq poke=%0d op=%0d #%0d: got (%0d,%0d,%0d) expected (%0d,%0d,%0d)",
                               poke, o, idx, tr[i].g1, tr[i].g2, tr[i].sp, e1, e2, esp);
            end
            idx++;
         end
         st = summarize(o);
         total++;
         if (st.nv !== 6 || st.nd !== 1 || st.donec !== st.lastc + 1 || st.opbad !== 0) begin
            bad++; $display("FAIL rand_frame poke=%0d op=%0d: got valid=%0d done=%0d donec=%0d lastc=%0d opbad=%0d expected 6/1/lastc+1/0",
                            poke, o, st.nv, st.nd, st.donec, st.lastc, st.opbad);
         end
      end
   endtask

   task automatic test_reset_mid_run;
      int  nd;
      bit  to;
      int  first;
      st_t st;
      @(negedge clk);
      drive(1'b0, 1'b1, 1'b0, 1'b0);
      @(negedge clk);
      drive(1'b0, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      rstn = 1'b0;
      @(negedge clk);
      total++;
      if ({busy3, done3, op3, sp3, v3, last3, g13, g23, stg3} !== 32'b0) begin
         bad++; $display("FAIL midreset_clear: got busy=%b v=%b g1=%0d g2=%0d stg=%0d expected 0", busy3, v3, g13, g23, stg3);
      end
      rstn = 1'b1;
      nd = 0;
      repeat (4) begin
         @(negedge clk);
         if (done3 || busy3) nd++;
      end
      total++;
      if (nd !== 0) begin bad++; $display("FAIL midreset_nodone: got %0d active cycles expected 0", nd); end
      run(1'b0, 1'b0, 0, 64'b0, 1'b0, to);
      first = -1;
      foreach (tr[i]) if (tr[i].v && first < 0) first = i;
      total++;
      if (first < 0 || tr[first].g1 !== 1 || tr[first].g2 !== 1) begin
         bad++; $display("FAIL midreset_restart: got first valid at cyc %0d expected pair (1,1) at cyc 0", first);
      end
      st = summarize(1'b0);
      total++;
      if (to !== 1'b0 || st.nv !== 6 || st.nd !== 1) begin
         bad++; $display("FAIL midreset_frame: got to=%0d valid=%0d done=%0d expected 0/6/1", to, st.nv, st.nd);
      end
   endtask

   task automatic test_full_size(input bit o, input int pct);
      bit   to;
      st_t  st;
      obs_t vq[$];
      int   e1, e2, est, sp_lo, sp_hi;
      bit   esp;
      run(1'b1, o, pct, 64'b0, 1'b0, to);
      total++;
      if (to !== 1'b0) begin bad++; $display("FAIL full_timeout op=%0d", o); end
      foreach (tr[i]) if (tr[i].v) vq.push_back(tr[i]);
      foreach (vq[i]) begin
         model(8, o, i, e1, e2, esp, est);
         total++;
         if (vq[i].g1 !== e1 || vq[i].g2 !== e2 || vq[i].sp !== esp || vq[i].stg !== est) begin
            bad++; $display("FAIL full_seq op=%0d #%0d: got (%0d,%0d,%0d,s%0d) expected (%0d,%0d,%0d,s%0d)",
                            o, i, vq[i].g1, vq[i].g2, vq[i].sp, vq[i].stg, e1, e2, esp, est);
         end
      end
      st = summarize(o);
      total++;
      if (st.nv !== 512 || st.nd !== 1 || st.donec !== st.lastc + 1 || st.lastv !== 511) begin
         bad++; $display("FAIL full_frame op=%0d: got valid=%0d done=%0d donec=%0d lastc=%0d lastv=%0d expected 512/1/lastc+1/511",
                         o, st.nv, st.nd, st.donec, st.lastc, st.lastv);
      end
      if (!o && vq.size() == 512) begin
         total++;
         if (vq[0].g1 !== 1 || vq[0].g2 !== 1) begin
            bad++; $display("FAIL full_first: got (%0d,%0d) expected (1,1)", vq[0].g1, vq[0].g2);
         end
         total++;
         if (vq[448].g1 !== 128 || vq[448].g2 !== 129 || vq[511].g1 !== 254 || vq[511].g2 !== 255) begin
            bad++; $display("FAIL full_ends: got (%0d,%0d)..(%0d,%0d) expected (128,129)..(254,255)",
                            vq[448].g1, vq[448].g2, vq[511].g1, vq[511].g2);
         end
         sp_lo = 0; sp_hi = 0;
         foreach (vq[i]) if (vq[i].sp) begin
            if (i < 448) sp_lo++; else sp_hi++;
         end
         total++;
         if (sp_lo !== 0 || sp_hi !== 64) begin
            bad++; $display("FAIL full_special: got early=%0d late=%0d expected 0/64", sp_lo, sp_hi);
         end
      end
   endtask

   initial begin
      test_reset();
      test_fixed_tables(1'b0);
      test_fixed_tables(1'b1);
      test_stall_hold();
      test_random_stall(1'b0);
      test_random_stall(1'b1);
      test_reset_mid_run();
      test_full_size(1'b0, 0);
      test_full_size(1'b1, 30);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
